// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package cla_seq_adder_ctrl_pkg;

    // Width of the shared lookahead slice; the sequencer walks operands in
    // steps of this many bits.
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of nibble slices needed for a given operand width.
    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand and result handshake bundle for the sequential adder.
// master: the ALU-side producer/consumer; slave: the adder itself.
interface cla_seq_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/cla_seq_adder_ctrl_cla.sv
// 4-bit carry-lookahead slice, purely combinational.
module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Carries are flattened so no carry depends on a lower carry output.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract built around one shared 4-bit CLA.
// WIDTH must be a multiple of 4 and at least 8.
//
//   state | meaning
//   IDLE  | ready for an operand bundle
//   RUN   | one nibble per cycle, LSB first, carry registered between nibbles
//   DONE  | result presented until the consumer takes it
module cla_seq_adder_ctrl
    import cla_seq_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_seq_adder_ctrl_if.slave  bus
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t state_q;
    state_t state_d;

    logic [IDX_W-1:0]    idx_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    sum_q;
    logic                carry_q;
    logic                cout_q;
    logic                ovf_q;

    logic                in_ready_c;
    logic                out_valid_c;
    logic                accept;
    logic                last_nib;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] cla_sum;
    logic                cla_cout;

    assign accept   = bus.in_valid && in_ready_c;
    assign last_nib = (idx_q == LAST_IDX);

    assign a_nib = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

    cla u_cla (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // State register; reset wins over any handshake in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: RUN always lasts exactly NIB cycles, DONE holds until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid) state_d = RUN;
            RUN:  if (last_nib)     state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only, so consuming a result can
    // never re-open the input side in the same cycle.
    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE:    in_ready_c  = 1'b1;
            DONE:    out_valid_c = 1'b1;
            default: ;
        endcase
    end

    // Operand capture and nibble-serial datapath. The result registers are
    // not touched on accept so the previous result stays visible until the
    // first RUN cycle overwrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub | bus.cin;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q[idx_q*NIBBLE_W +: NIBBLE_W] <= cla_sum;
            carry_q <= cla_cout;
            if (last_nib) begin
                // The MSB of the top nibble is the sign of the result.
                cout_q <= cla_cout;
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (cla_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
module tb_cla_seq_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } result_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    result_t exp_q[$];

    cla_seq_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic result_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                      input logic cv, input logic sv);
        result_t r;
        logic [WIDTH-1:0] be;
        logic [WIDTH:0]   full;
        logic             ci;
        be   = sv ? ~bv : bv;
        ci   = sv ? 1'b1 : cv;
        full = {1'b0, av} + {1'b0, be} + {{WIDTH{1'b0}}, ci};
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (av[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != av[WIDTH-1]);
        return r;
    endfunction

    // Wait (at negedges) for in_ready, bounded.
    task automatic wait_in_ready(input string name);
        int n;
        n = 0;
        while (!bus.in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s: in_ready timeout, got %0b want 1", name, bus.in_ready);
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic sv, input bit early_rdy,
                          input string name);
        int lat;
        result_t exp_r;
        @(negedge clk);
        wait_in_ready(name);
        bus.a         = av;
        bus.b         = bv;
        bus.cin       = cv;
        bus.sub       = sv;
        bus.in_valid  = 1'b1;
        bus.out_ready = early_rdy;
        exp_q.push_back(model(av, bv, cv, sv));
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== NIB + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, NIB + 1);
        end
        if (bus.out_valid && exp_q.size() > 0) begin
            exp_r = exp_q.pop_front();
            checks++;
            if (bus.sum !== exp_r.sum) begin
                errors++;
                $display("FAIL %s sum: got %h want %h", name, bus.sum, exp_r.sum);
            end
            checks++;
            if (bus.cout !== exp_r.cout) begin
                errors++;
                $display("FAIL %s cout: got %b want %b", name, bus.cout, exp_r.cout);
            end
            checks++;
            if (bus.ovf !== exp_r.ovf) begin
                errors++;
                $display("FAIL %s ovf: got %b want %b", name, bus.ovf, exp_r.ovf);
            end
        end else begin
            exp_q.delete();
            checks++;
            errors++;
            $display("FAIL %s result: out_valid got %b want 1", name, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: out_valid/in_ready got %b/%b want 0/1",
                     name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset handshake: in_ready/out_valid got %b/%b want 1/0",
                     bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.sum !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset result: sum/cout/ovf got %h/%b/%b want 0000/0/0",
                     bus.sum, bus.cout, bus.ovf);
        end
    endtask

    task automatic test_directed();
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, "add_carry_nibble");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "full_ripple");
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, "sub_borrow");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "add_ovf");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, "sub_ovf");
        run_op(16'h1234, 16'h0FF0, 1'b1, 1'b0, 1'b1, "add_cin_early_ready");
    endtask

    task automatic test_backpressure();
        int n;
        result_t exp_r;
        @(negedge clk);
        wait_in_ready("bp");
        bus.a        = 16'h1357;
        bus.b        = 16'h2468;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        exp_q.push_back(model(16'h1357, 16'h2468, 1'b0, 1'b0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        exp_r = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.sum !== exp_r.sum) begin
            errors++;
            $display("FAIL bp first: out_valid/sum got %b/%h want 1/%h",
                     bus.out_valid, bus.sum, exp_r.sum);
        end
        bus.a        = 16'hFFFF;
        bus.b        = 16'hFFFF;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.sum !== exp_r.sum || bus.cout !== exp_r.cout) begin
                errors++;
                $display("FAIL bp hold %0d: out_valid/in_ready/sum/cout got %b/%b/%h/%b want 1/0/%h/%b",
                         i, bus.out_valid, bus.in_ready, bus.sum, bus.cout,
                         exp_r.sum, exp_r.cout);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== exp_r.sum) begin
            errors++;
            $display("FAIL bp release: out_valid/in_ready/sum got %b/%b/%h want 0/1/%h",
                     bus.out_valid, bus.in_ready, bus.sum, exp_r.sum);
        end
        run_op(16'h0102, 16'h0304, 1'b0, 1'b0, 1'b0, "after_bp");
    endtask

    task automatic test_reset_mid_run();
        int seen;
        @(negedge clk);
        wait_in_ready("rst_mid");
        bus.a        = 16'hABCD;
        bus.b        = 16'h1111;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.sum !== '0 || bus.cout !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid state: in_ready/out_valid/sum/cout got %b/%b/%h/%b want 1/0/0000/0",
                     bus.in_ready, bus.out_valid, bus.sum, bus.cout);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_mid no_valid: out_valid cycles got %0d want 0", seen);
        end
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        for (int i = 0; i < 12; i++) begin
            av = WIDTH'($urandom);
            bv = WIDTH'($urandom);
            run_op(av, bv, 1'($urandom), 1'($urandom), 1'(i % 2), "random");
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
